// File: rtl/conv_cmd_splitter_if.sv
// Handshake bundle for conv_cmd_splitter: command in, DMA bursts out,
// burst completions in, finish tags out.
interface conv_cmd_splitter_if;
    logic        s_cmd_valid;
    logic        s_cmd_ready;
    logic [31:0] s_cmd_addr;
    logic [23:0] s_cmd_len;
    logic [3:0]  s_cmd_tag;
    logic        m_dma_valid;
    logic        m_dma_ready;
    logic [31:0] m_dma_addr;
    logic [12:0] m_dma_len;
    logic        m_dma_last;
    logic        dma_done;
    logic        m_fin_valid;
    logic        m_fin_ready;
    logic [3:0]  m_fin_tag;

    modport slave (
        input  s_cmd_valid, s_cmd_addr, s_cmd_len, s_cmd_tag,
        input  m_dma_ready, dma_done, m_fin_ready,
        output s_cmd_ready, m_dma_valid, m_dma_addr, m_dma_len, m_dma_last,
        output m_fin_valid, m_fin_tag
    );

    modport master (
        output s_cmd_valid, s_cmd_addr, s_cmd_len, s_cmd_tag,
        output m_dma_ready, dma_done, m_fin_ready,
        input  s_cmd_ready, m_dma_valid, m_dma_addr, m_dma_len, m_dma_last,
        input  m_fin_valid, m_fin_tag
    );
endinterface

// File: rtl/conv_cmd_splitter.sv
// Splits block-transfer commands into DMA bursts bounded by MAX_BURST_BYTES and
// 4 KB pages, tracks outstanding bursts and reports each command's tag when done.
module conv_cmd_splitter #(
    parameter int ATOMIC_C        = 4,
    parameter int MAX_BURST_BYTES = 256,
    parameter int MAX_OUTSTANDING = 8,
    parameter int SIM_DELAY       = 1
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 aclken,
    conv_cmd_splitter_if.slave   io,
    output logic                 busy,
    output logic                 err_unexp_done
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SPLIT     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_FIN       = 2'd3
    } state_t;

    localparam int          GLOG       = $clog2(ATOMIC_C * 2);
    localparam logic [31:0] ADDR_MASK  = ~((32'd1 << GLOG) - 32'd1);
    localparam logic [23:0] LEN_MASK   = ~((24'd1 << GLOG) - 24'd1);
    localparam logic [23:0] MAX_BURST  = 24'(MAX_BURST_BYTES);
    localparam logic [12:0] MAX_BURST13 = 13'(MAX_BURST_BYTES);
    localparam logic [3:0]  MAX_OUT    = 4'(MAX_OUTSTANDING);

    // Burst size: limited by remaining bytes, burst cap and distance to the next 4 KB page.
    function automatic logic [12:0] burst_bytes(input logic [11:0] page_off, input logic [23:0] rem);
        logic [12:0] to_page;
        logic [12:0] capped;
        to_page = 13'd4096 - {1'b0, page_off};
        capped  = (rem < MAX_BURST) ? rem[12:0] : MAX_BURST13;
        return (to_page < capped) ? to_page : capped;
    endfunction

    state_t      state_r, state_nxt_s;
    logic [31:0] addr_r, addr_nxt_s;
    logic [23:0] rem_r, rem_nxt_s;
    logic [3:0]  tag_r, tag_nxt_s;
    logic [3:0]  outstanding_r, out_nxt_s;
    logic        err_r, err_nxt_s;
    logic [12:0] nxt_len_s;

    logic        cmd_ready_r;
    logic        dma_valid_r;
    logic [12:0] dma_len_r;
    logic        dma_last_r;
    logic        fin_valid_r;
    logic        busy_r;

    logic        cmd_hs_s, dma_hs_s, fin_hs_s, done_s;
    logic [23:0] cmd_len_s;
    logic        unused_sim_delay_s;

    assign unused_sim_delay_s = (SIM_DELAY != 0);

    assign cmd_hs_s  = aclken & cmd_ready_r & io.s_cmd_valid;
    assign dma_hs_s  = aclken & dma_valid_r & io.m_dma_ready;
    assign fin_hs_s  = aclken & fin_valid_r & io.m_fin_ready;
    assign done_s    = aclken & io.dma_done;
    assign cmd_len_s = io.s_cmd_len & LEN_MASK;

    // Outstanding-burst counter and unexpected-completion flag update.
    always_comb begin
        out_nxt_s = outstanding_r;
        err_nxt_s = err_r;
        case ({dma_hs_s, done_s})
            2'b10: out_nxt_s = outstanding_r + 4'd1;
            2'b01: begin
                if (outstanding_r == 4'd0) begin
                    err_nxt_s = 1'b1;
                end else begin
                    out_nxt_s = outstanding_r - 4'd1;
                end
            end
            default: out_nxt_s = outstanding_r;
        endcase
    end

    // Next-state and datapath logic of the command FSM.
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = addr_r;
        rem_nxt_s   = rem_r;
        tag_nxt_s   = tag_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_hs_s) begin
                    addr_nxt_s  = io.s_cmd_addr & ADDR_MASK;
                    rem_nxt_s   = cmd_len_s;
                    tag_nxt_s   = io.s_cmd_tag;
                    state_nxt_s = (cmd_len_s != 24'd0) ? ST_SPLIT : ST_FIN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SPLIT: begin
                // The registered burst outputs always describe the burst at addr_r/rem_r.
                if (dma_hs_s) begin
                    addr_nxt_s  = addr_r + {19'd0, dma_len_r};
                    rem_nxt_s   = rem_r - {11'd0, dma_len_r};
                    state_nxt_s = dma_last_r ? ST_WAIT_DONE : ST_SPLIT;
                end else begin
                    state_nxt_s = ST_SPLIT;
                end
            end
            ST_WAIT_DONE: begin
                if (aclken && (out_nxt_s == 4'd0)) begin
                    state_nxt_s = ST_FIN;
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            ST_FIN: begin
                if (fin_hs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FIN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
        nxt_len_s = burst_bytes(addr_nxt_s[11:0], rem_nxt_s);
    end

    // State, address, remaining length, tag, counter and error registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r       <= ST_IDLE;
            addr_r        <= 32'd0;
            rem_r         <= 24'd0;
            tag_r         <= 4'd0;
            outstanding_r <= 4'd0;
            err_r         <= 1'b0;
        end else if (aclken) begin
            state_r       <= state_nxt_s;
            addr_r        <= addr_nxt_s;
            rem_r         <= rem_nxt_s;
            tag_r         <= tag_nxt_s;
            outstanding_r <= out_nxt_s;
            err_r         <= err_nxt_s;
        end
    end

    // Handshake outputs are registered from the next-state values.
    always_ff @(posedge aclk) begin
        if (areset) begin
            cmd_ready_r <= 1'b1;
            dma_valid_r <= 1'b0;
            dma_len_r   <= 13'd0;
            dma_last_r  <= 1'b0;
            fin_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else if (aclken) begin
            cmd_ready_r <= (state_nxt_s == ST_IDLE);
            dma_valid_r <= (state_nxt_s == ST_SPLIT) && (out_nxt_s < MAX_OUT);
            dma_len_r   <= nxt_len_s;
            dma_last_r  <= (state_nxt_s == ST_SPLIT) && ({11'd0, nxt_len_s} == rem_nxt_s);
            fin_valid_r <= (state_nxt_s == ST_FIN);
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end

    assign io.s_cmd_ready = cmd_ready_r;
    assign io.m_dma_valid = dma_valid_r;
    assign io.m_dma_addr  = addr_r;
    assign io.m_dma_len   = dma_len_r;
    assign io.m_dma_last  = dma_last_r;
    assign io.m_fin_valid = fin_valid_r;
    assign io.m_fin_tag   = tag_r;
    assign busy           = busy_r;
    assign err_unexp_done = err_r;

endmodule

// File: tb/tb_conv_cmd_splitter.sv
// Directed bench for conv_cmd_splitter: page splitting, zero length, backpressure,
// outstanding cap, unexpected completion, clock enable and mid-command reset.
module tb_conv_cmd_splitter;

    logic aclk = 1'b0;
    logic areset;
    logic aclken;
    logic busy;
    logic err;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   issued;
    int   dones;

    conv_cmd_splitter_if bus_if ();

    conv_cmd_splitter #(
        .ATOMIC_C(4),
        .MAX_BURST_BYTES(256),
        .MAX_OUTSTANDING(8),
        .SIM_DELAY(1)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .aclken(aclken),
        .io(bus_if.slave),
        .busy(busy),
        .err_unexp_done(err)
    );

    always #5 aclk = ~aclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge aclk);
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic [23:0] l, input logic [3:0] t);
        check("cmd_ready", 32'(bus_if.s_cmd_ready), 32'd1);
        bus_if.s_cmd_valid = 1'b1;
        bus_if.s_cmd_addr  = a;
        bus_if.s_cmd_len   = l;
        bus_if.s_cmd_tag   = t;
        cyc();
        bus_if.s_cmd_valid = 1'b0;
    endtask

    task automatic expect_burst(input string tag, input logic [31:0] a, input logic [12:0] l, input logic last);
        check({tag, "_valid"}, 32'(bus_if.m_dma_valid), 32'd1);
        check({tag, "_addr"}, bus_if.m_dma_addr, a);
        check({tag, "_len"}, 32'(bus_if.m_dma_len), 32'(l));
        check({tag, "_last"}, 32'(bus_if.m_dma_last), 32'(last));
    endtask

    task automatic burst_done();
        bus_if.m_dma_ready = 1'b1;
        cyc();
        bus_if.m_dma_ready = 1'b0;
        bus_if.dma_done    = 1'b1;
        cyc();
        bus_if.dma_done    = 1'b0;
    endtask

    task automatic finish_cmd(input string tag, input logic [3:0] t);
        check({tag, "_fin_valid"}, 32'(bus_if.m_fin_valid), 32'd1);
        check({tag, "_fin_tag"}, 32'(bus_if.m_fin_tag), 32'(t));
        check({tag, "_dma_idle"}, 32'(bus_if.m_dma_valid), 32'd0);
        bus_if.m_fin_ready = 1'b1;
        cyc();
        bus_if.m_fin_ready = 1'b0;
        check({tag, "_fin_drop"}, 32'(bus_if.m_fin_valid), 32'd0);
        check({tag, "_busy_clr"}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(bus_if.s_cmd_ready), 32'd1);
        check({tag, "_dma_valid"}, 32'(bus_if.m_dma_valid), 32'd0);
        check({tag, "_dma_addr"}, bus_if.m_dma_addr, 32'd0);
        check({tag, "_dma_len"}, 32'(bus_if.m_dma_len), 32'd0);
        check({tag, "_dma_last"}, 32'(bus_if.m_dma_last), 32'd0);
        check({tag, "_fin_valid"}, 32'(bus_if.m_fin_valid), 32'd0);
        check({tag, "_fin_tag"}, 32'(bus_if.m_fin_tag), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        areset             = 1'b1;
        aclken             = 1'b1;
        bus_if.s_cmd_valid = 1'b0;
        bus_if.s_cmd_addr  = 32'd0;
        bus_if.s_cmd_len   = 24'd0;
        bus_if.s_cmd_tag   = 4'd0;
        bus_if.m_dma_ready = 1'b0;
        bus_if.dma_done    = 1'b0;
        bus_if.m_fin_ready = 1'b0;
        cyc();
        cyc();
        check_reset_outputs("rst");
        areset = 1'b0;
        cyc();

        // 4 KB boundary split with a completion after every burst
        send_cmd(32'h0000_0F80, 24'h000200, 4'd5);
        check("page_busy", 32'(busy), 32'd1);
        expect_burst("page_b0", 32'h0000_0F80, 13'd128, 1'b0);
        burst_done();
        expect_burst("page_b1", 32'h0000_1000, 13'd256, 1'b0);
        burst_done();
        expect_burst("page_b2", 32'h0000_1100, 13'd128, 1'b1);
        burst_done();
        finish_cmd("page", 4'd5);

        // Zero-length command goes straight to finish
        send_cmd(32'h0000_0040, 24'h000000, 4'd3);
        finish_cmd("zero", 4'd3);

        // Backpressure: outputs hold while m_dma_ready is low
        send_cmd(32'h0000_0100, 24'h000300, 4'd7);
        for (int b = 0; b < 3; b++) begin
            for (int s = 0; s < 5; s++) begin
                expect_burst("bp_stall", 32'h0000_0100 + 32'(b) * 32'h100, 13'd256, (b == 2));
                cyc();
            end
            burst_done();
        end
        finish_cmd("bp", 4'd7);

        // Outstanding cap: 16 bursts, no completions at first
        send_cmd(32'h0000_0000, 24'h001000, 4'd9);
        bus_if.m_dma_ready = 1'b1;
        issued = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus_if.m_dma_valid) issued++;
            cyc();
        end
        check("cap_issued", 32'(issued), 32'd8);
        check("cap_valid_low", 32'(bus_if.m_dma_valid), 32'd0);
        check("cap_addr_hold", bus_if.m_dma_addr, 32'h0000_0800);
        bus_if.m_dma_ready = 1'b0;
        bus_if.dma_done    = 1'b1;
        cyc();
        bus_if.dma_done    = 1'b0;
        expect_burst("cap_b8", 32'h0000_0800, 13'd256, 1'b0);
        // completion coinciding with a handshake keeps the count unchanged
        bus_if.m_dma_ready = 1'b1;
        bus_if.dma_done    = 1'b1;
        cyc();
        bus_if.dma_done    = 1'b0;
        expect_burst("cap_b9", 32'h0000_0900, 13'd256, 1'b0);
        cyc();
        check("cap_full_again", 32'(bus_if.m_dma_valid), 32'd0);
        check("cap_addr_b10", bus_if.m_dma_addr, 32'h0000_0A00);
        issued = 10;
        dones  = 2;
        for (int i = 0; i < 60 && !bus_if.m_fin_valid; i++) begin
            if (bus_if.m_dma_valid) begin
                check("cap_drain_last", 32'(bus_if.m_dma_last), 32'(issued == 15));
                issued++;
            end
            bus_if.dma_done = (dones < 16);
            if (dones < 16) dones++;
            cyc();
            bus_if.dma_done = 1'b0;
        end
        bus_if.m_dma_ready = 1'b0;
        check("cap_total", 32'(issued), 32'd16);
        check("cap_err_clear", 32'(err), 32'd0);
        finish_cmd("cap", 4'd9);

        // Unexpected completion while idle
        bus_if.dma_done = 1'b1;
        cyc();
        bus_if.dma_done = 1'b0;
        check("unexp_err", 32'(err), 32'd1);
        check("unexp_idle", 32'(bus_if.s_cmd_ready), 32'd1);
        // a single burst must still issue, so the counter did not wrap
        send_cmd(32'h0000_0040, 24'h000040, 4'd1);
        expect_burst("unexp_b0", 32'h0000_0040, 13'd64, 1'b1);
        aclken             = 1'b0;
        bus_if.m_dma_ready = 1'b1;
        cyc();
        cyc();
        expect_burst("cken_hold", 32'h0000_0040, 13'd64, 1'b1);
        aclken = 1'b1;
        cyc();
        bus_if.m_dma_ready = 1'b0;
        check("unexp_wait_valid", 32'(bus_if.m_dma_valid), 32'd0);
        check("unexp_wait_fin", 32'(bus_if.m_fin_valid), 32'd0);
        bus_if.dma_done = 1'b1;
        cyc();
        bus_if.dma_done = 1'b0;
        finish_cmd("unexp", 4'd1);
        check("unexp_sticky", 32'(err), 32'd1);

        // Reset after the second burst of a four-burst command
        send_cmd(32'h0000_2000, 24'h000400, 4'd10);
        bus_if.m_dma_ready = 1'b1;
        cyc();
        cyc();
        bus_if.m_dma_ready = 1'b0;
        check("mid_b2_addr", bus_if.m_dma_addr, 32'h0000_2200);
        areset = 1'b1;
        cyc();
        check_reset_outputs("mid_rst");
        areset          = 1'b0;
        bus_if.dma_done = 1'b1;
        cyc();
        bus_if.dma_done = 1'b0;
        check("mid_late_done_err", 32'(err), 32'd1);
        // unaligned low bits are dropped to the 8-byte granule
        send_cmd(32'h0000_3047, 24'h000085, 4'd12);
        expect_burst("mid_new_b0", 32'h0000_3040, 13'd128, 1'b1);
        burst_done();
        finish_cmd("mid_new", 4'd12);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
